// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit CPU datapath.
// Gates the datapath strobes phase by phase; handles HLT, single-step, wait states and timeouts.
module cpu_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             mem_ready,
    input  logic             dec_ldr,
    input  logic             dec_str,
    input  logic             dec_br,
    input  logic             dec_jmp,
    input  logic             dec_outr,
    input  logic             dec_hlt,
    input  logic             dec_rf_wr,
    input  logic             dec_psw,
    input  logic             cond_true,
    input  logic             out_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_wr_en,
    output logic             psw_wr_en,
    output logic             out_valid,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_OUT    = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t              r_state;
    state_t              w_next;
    state_t              w_resume;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_err;
    logic [CNT_W-1:0]    r_instr_count;
    logic                w_retire;
    logic                w_mem_pending;
    logic                w_timeout;

    // Only the FETCH and MEM phases wait on mem_ready; elsewhere it is ignored.
    assign w_mem_pending = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timeout     = (TIMEOUT != 0) && w_mem_pending && !mem_ready &&
                           ((int'(r_wait_cnt) + 1) == TIMEOUT);
    assign w_resume      = step_mode ? S_IDLE : S_FETCH;

    // NOTE: every output and next-state term gets a default before the case so no latch is inferred.
    always_comb begin
        w_next    = r_state;
        w_retire  = 1'b0;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_wr_en  = 1'b0;
        psw_wr_en = 1'b0;
        out_valid = 1'b0;
        halted    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                if (dec_hlt) begin
                    w_retire = 1'b1;
                    w_next   = S_HALT;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                psw_wr_en = dec_psw;
                pc_load   = dec_jmp | (dec_br & cond_true);
                // LDR writes the register file later, from WB, once the data has arrived.
                rf_wr_en  = dec_rf_wr & ~dec_ldr;
                if (dec_ldr || dec_str) begin
                    w_next = S_MEM;
                end else if (dec_outr) begin
                    w_next = S_OUT;
                end else begin
                    w_retire = 1'b1;
                    w_next   = w_resume;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_str & ~dec_ldr;
                if (mem_ready) begin
                    if (dec_ldr) begin
                        w_next = S_WB;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = w_resume;
                    end
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_WB: begin
                rf_wr_en = 1'b1;
                w_retire = 1'b1;
                w_next   = w_resume;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_retire = 1'b1;
                    w_next   = w_resume;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) w_next = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_err         <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;

            // Every entry into FETCH or MEM is a state change, so the wait count restarts there.
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_mem_pending && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_timeout) r_err <= 1'b1;

            if (w_retire) r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign err         = r_err;
    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle state, strobe and retire-count expectations.
// Each task walks a hand-derived cycle table and compares before every rising edge.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, step_mode, mem_ready;
    logic        dec_ldr, dec_str, dec_br, dec_jmp, dec_outr, dec_hlt, dec_rf_wr, dec_psw;
    logic        cond_true, out_ready;
    logic        imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we;
    logic        rf_wr_en, psw_wr_en, out_valid, halted, err;
    logic [2:0]  state;
    logic [15:0] instr_count;

    cpu_sequencer #(.CNT_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .mem_ready(mem_ready),
        .dec_ldr(dec_ldr), .dec_str(dec_str), .dec_br(dec_br), .dec_jmp(dec_jmp),
        .dec_outr(dec_outr), .dec_hlt(dec_hlt), .dec_rf_wr(dec_rf_wr), .dec_psw(dec_psw),
        .cond_true(cond_true), .out_ready(out_ready),
        .imem_req(imem_req), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_wr_en(rf_wr_en), .psw_wr_en(psw_wr_en),
        .out_valid(out_valid), .halted(halted), .err(err), .state(state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                           MEM  = 3'd4, WB    = 3'd5, OUT    = 3'd6, HALT = 3'd7;

    localparam logic [10:0] O_ERR  = 11'h400, O_IMEM = 11'h200, O_IR  = 11'h100,
                            O_PCI  = 11'h080, O_PCL  = 11'h040, O_DREQ = 11'h020,
                            O_DWE  = 11'h010, O_RF   = 11'h008, O_PSW = 11'h004,
                            O_OV   = 11'h002, O_HLT  = 11'h001;
    localparam logic [10:0] O_F    = O_IMEM | O_IR | O_PCI;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = 16'd0;

    function automatic logic [10:0] outs();
        return {err, imem_req, ir_load, pc_inc, pc_load, dmem_req, dmem_we,
                rf_wr_en, psw_wr_en, out_valid, halted};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic ldr, str, br, jmp, outr, hlt, rfw, psw);
        dec_ldr = ldr; dec_str = str; dec_br = br; dec_jmp = jmp;
        dec_outr = outr; dec_hlt = hlt; dec_rf_wr = rfw; dec_psw = psw;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; mem_ready = 1'b1;
        cond_true = 1'b0; out_ready = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        n_cmp++;
        if (state !== IDLE || outs() !== 11'h000 || instr_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset: got state=%0d outs=%h cnt=%0d, want state=0 outs=000 cnt=0",
                     state, outs(), instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_alu();
        logic [2:0]  es [8] = '{IDLE, FETCH, DECODE, EXEC, FETCH, DECODE, EXEC, IDLE};
        logic [10:0] eo [8] = '{11'h000, O_F, 11'h000, O_RF | O_PSW,
                                O_F, 11'h000, O_RF | O_PSW, 11'h000};
        int          dc [8] = '{0, 0, 0, 0, 1, 1, 1, 2};
        set_dec(0, 0, 0, 0, 0, 0, 1, 1);
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            start     = (i == 0);
            step_mode = (i >= 4);
            #2;
            n_cmp++;
            if (state !== es[i] || outs() !== eo[i] || instr_count !== exp_cnt + 16'(dc[i])) begin
                n_bad++;
                $display("FAIL alu row%0d: got state=%0d outs=%h cnt=%0d, want state=%0d outs=%h cnt=%0d",
                         i, state, outs(), instr_count, es[i], eo[i], exp_cnt + 16'(dc[i]));
            end
            cyc();
        end
        exp_cnt += 16'd2;
    endtask

    task automatic test_ldr();
        logic [2:0]  es [10] = '{IDLE, FETCH, DECODE, EXEC, MEM, MEM, MEM, MEM, WB, IDLE};
        logic [10:0] eo [10] = '{11'h000, O_F, 11'h000, 11'h000, O_DREQ, O_DREQ, O_DREQ,
                                 O_DREQ, O_RF, 11'h000};
        logic        mr [10] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
        set_dec(1, 0, 0, 0, 0, 0, 1, 0);
        step_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start     = (i == 0);
            mem_ready = mr[i];
            #2;
            n_cmp++;
            if (state !== es[i] || outs() !== eo[i] || instr_count !== exp_cnt + 16'(i == 9)) begin
                n_bad++;
                $display("FAIL ldr row%0d: got state=%0d outs=%h cnt=%0d, want state=%0d outs=%h cnt=%0d",
                         i, state, outs(), instr_count, es[i], eo[i], exp_cnt + 16'(i == 9));
            end
            cyc();
        end
        exp_cnt += 16'd1;
    endtask

    task automatic test_str();
        logic [2:0]  es [6] = '{IDLE, FETCH, DECODE, EXEC, MEM, IDLE};
        logic [10:0] eo [6] = '{11'h000, O_F, 11'h000, 11'h000, O_DREQ | O_DWE, 11'h000};
        set_dec(0, 1, 0, 0, 0, 0, 0, 0);
        step_mode = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start = (i == 0);
            #2;
            n_cmp++;
            if (state !== es[i] || outs() !== eo[i] || instr_count !== exp_cnt + 16'(i == 5)) begin
                n_bad++;
                $display("FAIL str row%0d: got state=%0d outs=%h cnt=%0d, want state=%0d outs=%h cnt=%0d",
                         i, state, outs(), instr_count, es[i], eo[i], exp_cnt + 16'(i == 5));
            end
            cyc();
        end
        exp_cnt += 16'd1;
    endtask

    // BEQ not taken, BEQ taken, BAL with a false condition, JAL (jump plus link write).
    task automatic test_branch();
        logic [2:0]  es [5] = '{IDLE, FETCH, DECODE, EXEC, IDLE};
        logic [10:0] ex [4] = '{11'h000, O_PCL, O_PCL, O_PCL | O_RF};
        logic [10:0] eo;
        step_mode = 1'b1;
        mem_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            set_dec(0, 0, v < 2, v >= 2, 0, 0, v == 3, 0);
            cond_true = (v == 1);
            for (int i = 0; i < 5; i++) begin
                start = (i == 0);
                eo = (i == 1) ? O_F : (i == 3) ? ex[v] : 11'h000;
                #2;
                n_cmp++;
                if (state !== es[i] || outs() !== eo || instr_count !== exp_cnt + 16'(i == 4)) begin
                    n_bad++;
                    $display("FAIL branch v%0d row%0d: got state=%0d outs=%h cnt=%0d, want state=%0d outs=%h cnt=%0d",
                             v, i, state, outs(), instr_count, es[i], eo, exp_cnt + 16'(i == 4));
                end
                cyc();
            end
            exp_cnt += 16'd1;
        end
        cond_true = 1'b0;
    endtask

    task automatic test_outr();
        logic [2:0]  es;
        logic [10:0] eo;
        set_dec(0, 0, 0, 0, 1, 0, 0, 0);
        step_mode = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            start     = (i == 0);
            out_ready = (i == 9);
            es = (i == 0 || i == 10) ? IDLE : (i == 1) ? FETCH : (i == 2) ? DECODE :
                 (i == 3) ? EXEC : OUT;
            eo = (i == 1) ? O_F : (i >= 4 && i <= 9) ? O_OV : 11'h000;
            #2;
            n_cmp++;
            if (state !== es || outs() !== eo || instr_count !== exp_cnt + 16'(i == 10)) begin
                n_bad++;
                $display("FAIL outr row%0d: got state=%0d outs=%h cnt=%0d, want state=%0d outs=%h cnt=%0d",
                         i, state, outs(), instr_count, es, eo, exp_cnt + 16'(i == 10));
            end
            cyc();
        end
        out_ready = 1'b0;
        exp_cnt += 16'd1;
    endtask

    task automatic test_hlt();
        logic [2:0]  es;
        logic [10:0] eo;
        int          dc;
        set_dec(0, 0, 0, 0, 0, 1, 0, 0);
        step_mode = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 28; i++) begin
            start = (i == 0) || (i == 23);
            if (i == 24) begin
                set_dec(0, 0, 0, 0, 0, 0, 0, 0);
                step_mode = 1'b1;
            end
            es = (i == 0 || i == 27) ? IDLE : (i == 1 || i == 24) ? FETCH :
                 (i == 2 || i == 25) ? DECODE : (i == 26) ? EXEC : HALT;
            eo = (i == 1 || i == 24) ? O_F : (i >= 3 && i <= 23) ? O_HLT : 11'h000;
            dc = (i <= 2) ? 0 : (i == 27) ? 2 : 1;
            #2;
            n_cmp++;
            if (state !== es || outs() !== eo || instr_count !== exp_cnt + 16'(dc)) begin
                n_bad++;
                $display("FAIL hlt row%0d: got state=%0d outs=%h cnt=%0d, want state=%0d outs=%h cnt=%0d",
                         i, state, outs(), instr_count, es, eo, exp_cnt + 16'(dc));
            end
            cyc();
        end
        exp_cnt += 16'd2;
    endtask

    task automatic test_timeout();
        logic [2:0]  es;
        logic [10:0] eo;
        set_dec(0, 0, 0, 0, 0, 0, 1, 0);
        step_mode = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start = (i == 0);
            es = (i == 0) ? IDLE : (i == 5) ? HALT : FETCH;
            eo = (i == 0) ? 11'h000 : (i == 5) ? (O_HLT | O_ERR) : O_IMEM;
            #2;
            n_cmp++;
            if (state !== es || outs() !== eo || instr_count !== exp_cnt) begin
                n_bad++;
                $display("FAIL timeout row%0d: got state=%0d outs=%h cnt=%0d, want state=%0d outs=%h cnt=%0d",
                         i, state, outs(), instr_count, es, eo, exp_cnt);
            end
            cyc();
        end
    endtask

    // Resumes from the timeout HALT with an LDR, then pulls reset during the MEM wait.
    task automatic test_reset_mid_mem();
        logic [2:0]  es [6] = '{HALT, FETCH, DECODE, EXEC, MEM, MEM};
        logic [10:0] eo [6] = '{O_HLT | O_ERR, O_F | O_ERR, O_ERR, O_ERR,
                                O_DREQ | O_ERR, O_DREQ | O_ERR};
        set_dec(1, 0, 0, 0, 0, 0, 1, 0);
        step_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start     = (i == 0);
            mem_ready = (i < 4);
            #2;
            n_cmp++;
            if (state !== es[i] || outs() !== eo[i] || instr_count !== exp_cnt) begin
                n_bad++;
                $display("FAIL midmem row%0d: got state=%0d outs=%h cnt=%0d, want state=%0d outs=%h cnt=%0d",
                         i, state, outs(), instr_count, es[i], eo[i], exp_cnt);
            end
            if (i < 5) cyc();
        end
        #1;
        rst_n = 1'b0;
        #1;
        exp_cnt = 16'd0;
        n_cmp++;
        if (state !== IDLE || outs() !== 11'h000 || instr_count !== 16'd0) begin
            n_bad++;
            $display("FAIL midmem_reset: got state=%0d outs=%h cnt=%0d, want state=0 outs=000 cnt=0",
                     state, outs(), instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        cyc();
        #2;
        n_cmp++;
        if (state !== IDLE || outs() !== 11'h000 || instr_count !== 16'd0) begin
            n_bad++;
            $display("FAIL post_reset: got state=%0d outs=%h cnt=%0d, want state=0 outs=000 cnt=0",
                     state, outs(), instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ldr();
        test_str();
        test_branch();
        test_outr();
        test_hlt();
        test_timeout();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle fetch/decode/execute sequencer for the 16-bit CPU datapath. It takes the instruction-class strobes and control enables from the combinational instruction decoder and steps the datapath through its phases. Per phase it gates PC update, IR load, PSW load, register-file write, data-memory access and OutR output. It also handles HLT, single-step, memory wait states and memory timeouts.

Parameters:
CNT_W, 16, width of retired-instruction counter
TIMEOUT, 255, max wait cycles on imem/dmem ready before error; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE/HALT and run; acts as step pulse in step mode
step_mode  in  1  1 = return to IDLE after every retired instruction
mem_ready  in  1  imem/dmem access complete this cycle
dec_ldr  in  1  decoded LDR
dec_str  in  1  decoded STR
dec_br  in  1  conditional branch (BCC/BCS/BNE/BEQ)
dec_jmp  in  1  unconditional transfer (BAL/JMP/JAL/JR)
dec_outr  in  1  decoded OutR
dec_hlt  in  1  decoded HLT
dec_rf_wr  in  1  decoder register-file write enable
dec_psw  in  1  decoder PSW update enable
cond_true  in  1  branch condition met, from flag logic
out_ready  in  1  output sink accepts out_valid
imem_req  out  1  instruction fetch request
ir_load  out  1  load IR
pc_inc  out  1  PC <= PC+1
pc_load  out  1  PC <= branch/jump target
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write
rf_wr_en  out  1  gated register-file write
psw_wr_en  out  1  gated PSW write
out_valid  out  1  OutR data valid
halted  out  1  in HALT state
err  out  1  sticky memory timeout flag
state  out  3  current state encoding
instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (async, rst_n=0): state=IDLE, instr_count=0, err=0, wait counter=0, all outputs 0. Reset mid-access abandons the access; no write pulse is produced.
- Only state, wait counter, err and instr_count are registered. Outputs are combinational from state plus the inputs named below.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, OUT=6, HALT=7.
- IDLE: start=1 -> FETCH.
- FETCH: imem_req=1 held until mem_ready. On mem_ready: ir_load=1 and pc_inc=1 for that cycle, then -> DECODE.
- DECODE: one cycle. If dec_hlt=1 -> HALT and the instruction retires; otherwise -> EXEC.
- Decode priority when strobes overlap: hlt > ldr > str > outr > br/jmp > ALU.
- EXEC:
  - psw_wr_en = dec_psw.
  - pc_load = dec_jmp | (dec_br & cond_true).
  - rf_wr_en = dec_rf_wr & ~dec_ldr (covers ALU ops and JAL link).
  - dec_ldr|dec_str -> MEM; dec_outr -> OUT; otherwise the instruction retires.
- MEM: dmem_req=1 and dmem_we=dec_str, held until mem_ready. On mem_ready: LDR -> WB; STR retires.
- WB: rf_wr_en=1 for one cycle; the instruction retires.
- OUT: out_valid=1 held until out_ready. The cycle with out_ready=1 retires the instruction.
- Retire: instr_count+1 (wraps 2^CNT_W-1 -> 0). Next state = IDLE if step_mode=1, else FETCH.
- HALT: halted=1. start=1 -> FETCH, resuming at the already-incremented PC.
- Decoder inputs must stay stable from DECODE through retire, since IR is held.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and counts each cycle while the request is pending and mem_ready=0.
  - If it reaches TIMEOUT (TIMEOUT≠0): err<=1 and -> HALT without ir_load, rf write or retire.
  - err clears only on reset.
- mem_ready in non-request states is ignored.
- start in FETCH..OUT is ignored.

Test Plan:
- ALU op, mem_ready tied 1, start pulse at cycle 0: states FETCH,DECODE,EXEC,FETCH across cycles 1–4. Require rf_wr_en=1 only in EXEC, ir_load and pc_inc only in FETCH, instr_count=1 after EXEC.
- LDR with mem_ready delayed 3 cycles in MEM: dmem_req held 4 cycles with dmem_we=0, then WB with a single rf_wr_en pulse. No rf_wr_en in EXEC.
- BEQ with cond_true=0, then cond_true=1: pc_load=0, then pc_load=1 in EXEC. BAL with cond_true=0: pc_load=1.
- OutR with out_ready low 5 cycles: out_valid high 6 cycles; instr_count increments on the out_ready cycle only.
- HLT: halted=1 and instr_count+1; the core stays in HALT for 20 cycles. A start pulse leads to FETCH the next cycle. step_mode=1 returns to IDLE after each instruction.
- TIMEOUT=4 with mem_ready stuck 0 in FETCH: err=1 and HALT after 4 wait cycles, no ir_load. Asserting rst_n=0 mid-MEM gives IDLE immediately, all outputs 0 and err=0.
